// File: rtl/ttt_sched_pkg.sv
// Shared types and constants for the TTT dispatch scheduler.
package ttt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int DEF_NUM_PROCESSORS = 10;
  localparam int DEF_NEW_TOKEN_BITS = 4;

  // Width of the optional statistics counters.
  localparam int STAT_W = 16;

  // Processor-id width; a single processor still needs one bit.
  function automatic int pid_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_PID_W = pid_width(DEF_NUM_PROCESSORS);

endpackage

// File: rtl/tt_um_jleugeri_ttt_rr_arbiter.sv
// Round-robin pick over the pending mask. Purely combinational: the search
// starts at ptr_i, walks upward and wraps; the pointer register is the
// parent's.
module tt_um_jleugeri_ttt_rr_arbiter
  import ttt_sched_pkg::*;
#(
  parameter int N = DEF_NUM_PROCESSORS,
  parameter int W = pid_width(N)
) (
  input  logic [N-1:0] pend_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         grant_valid_o
);

  // First set bit at or after the pointer, modulo N.
  always_comb begin
    int idx;
    idx           = 0;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!grant_valid_o && pend_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o       = W'(idx);
      end
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// TTT dispatch scheduler: collects processor fire requests in a pending
// mask, dispatches one source at a time to the connection network, and
// forwards each token-update beat to the processor array through a
// one-entry output register. Array back-pressure freezes the network.
// Build macro TTT_SCHED_STATS_EN adds saturating dispatch/merge counters.
module tt_um_jleugeri_ttt_scheduler
  import ttt_sched_pkg::*;
#(
  parameter  int NUM_PROCESSORS = DEF_NUM_PROCESSORS,
  parameter  int NEW_TOKEN_BITS = DEF_NEW_TOKEN_BITS,
  localparam int PID_W          = pid_width(NUM_PROCESSORS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fire_valid,
  input  logic [PID_W-1:0]          fire_id,
  input  logic                      sched_enable,
  output logic                      net_start,
  output logic [PID_W-1:0]          net_processor_id,
  output logic                      net_hold,
  input  logic                      net_valid,
  input  logic                      net_done,
  input  logic [PID_W-1:0]          net_target_id,
  input  logic [NEW_TOKEN_BITS-1:0] net_good,
  input  logic [NEW_TOKEN_BITS-1:0] net_bad,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [PID_W-1:0]          upd_target_id,
  output logic [NEW_TOKEN_BITS-1:0] upd_good,
  output logic [NEW_TOKEN_BITS-1:0] upd_bad,
  output logic                      busy,
  output logic                      pending_any
`ifdef TTT_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_dispatches,
  output logic [STAT_W-1:0]         stat_merged
`endif
);

  state_t                      state_q, state_d;
  logic [NUM_PROCESSORS-1:0]   pend_q, pend_d;
  logic [PID_W-1:0]            ptr_q, ptr_d;
  logic [PID_W-1:0]            pid_q, pid_d;
  logic                        upd_valid_q, upd_valid_d;
  logic [PID_W-1:0]            upd_tgt_q, upd_tgt_d;
  logic [NEW_TOKEN_BITS-1:0]   upd_good_q, upd_good_d;
  logic [NEW_TOKEN_BITS-1:0]   upd_bad_q, upd_bad_d;

  logic                        fire_ok;
  logic [NUM_PROCESSORS-1:0]   fire_set;
  logic [NUM_PROCESSORS-1:0]   grant_clr;
  logic [PID_W-1:0]            grant;
  logic                        grant_valid;
  logic                        dispatch;
  logic                        beat_acc;
  logic                        done_acc;

  // Out-of-range ids never reach the mask.
  assign fire_ok  = fire_valid && (int'(fire_id) < NUM_PROCESSORS);
  assign fire_set = fire_ok ? (NUM_PROCESSORS'(1) << fire_id) : '0;

  tt_um_jleugeri_ttt_rr_arbiter #(
    .N (NUM_PROCESSORS),
    .W (PID_W)
  ) u_arb (
    .pend_i        (pend_q),
    .ptr_i         (ptr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign dispatch  = (state_q == IDLE) && sched_enable && grant_valid;
  assign grant_clr = dispatch ? (NUM_PROCESSORS'(1) << grant) : '0;

  // Hold the network whenever the output register is full and not draining.
  assign net_hold = upd_valid_q & ~upd_ready;
  assign beat_acc = (state_q == STREAM) && net_valid && !net_hold;
  assign done_acc = (state_q == STREAM) && net_done && !net_hold;

  // Pending mask and pointer; a fire on the grant cycle re-sets the bit.
  always_comb begin
    pend_d = (pend_q & ~grant_clr) | fire_set;
    ptr_d  = ptr_q;
    if (dispatch)
      ptr_d = (grant == PID_W'(NUM_PROCESSORS - 1)) ? '0 : grant + 1'b1;
  end

  // Dispatch FSM: latch the winner, pulse start, stream until done.
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    unique case (state_q)
      IDLE: begin
        if (dispatch) begin
          pid_d   = grant;
          state_d = START;
        end
      end
      START:   state_d = STREAM;
      STREAM:  if (done_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on an accepted beat, drain on a handshake.
  always_comb begin
    upd_valid_d = upd_valid_q;
    upd_tgt_d   = upd_tgt_q;
    upd_good_d  = upd_good_q;
    upd_bad_d   = upd_bad_q;
    if (beat_acc) begin
      upd_valid_d = 1'b1;
      upd_tgt_d   = net_target_id;
      upd_good_d  = net_good;
      upd_bad_d   = net_bad;
    end else if (upd_ready) begin
      upd_valid_d = 1'b0;
    end
  end

  // State registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      pid_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_tgt_q   <= '0;
      upd_good_q  <= '0;
      upd_bad_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      pid_q       <= pid_d;
      upd_valid_q <= upd_valid_d;
      upd_tgt_q   <= upd_tgt_d;
      upd_good_q  <= upd_good_d;
      upd_bad_q   <= upd_bad_d;
    end
  end

  assign net_start        = (state_q == START);
  assign net_processor_id = pid_q;
  assign upd_valid        = upd_valid_q;
  assign upd_target_id    = upd_tgt_q;
  assign upd_good         = upd_good_q;
  assign upd_bad          = upd_bad_q;
  assign busy             = (state_q != IDLE);
  assign pending_any      = |pend_q;

`ifdef TTT_SCHED_STATS_EN
  logic [STAT_W-1:0] disp_cnt_q, disp_cnt_d;
  logic [STAT_W-1:0] merge_cnt_q, merge_cnt_d;
  logic              merged;

  // A fire whose bit is already set (including one being granted) merges.
  assign merged = |(pend_q & fire_set);

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    disp_cnt_d  = disp_cnt_q;
    merge_cnt_d = merge_cnt_q;
    if (net_start && !(&disp_cnt_q)) disp_cnt_d = disp_cnt_q + STAT_W'(1);
    if (merged && !(&merge_cnt_q))   merge_cnt_d = merge_cnt_q + STAT_W'(1);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_cnt_q  <= '0;
      merge_cnt_q <= '0;
    end else begin
      disp_cnt_q  <= disp_cnt_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign stat_dispatches = disp_cnt_q;
  assign stat_merged     = merge_cnt_q;
`endif

endmodule
